// File: rtl/control_sequencer_pkg.sv
// cpu_ctrl_pkg: constants and helpers shared by the control sequencer.
//   state_t     - sequencer state encodings
//   OP_*        - 5-bit opcode constants (IR[31:27])
//   ALU_*       - bit indices into the 13-bit one-hot alu_op bus
//   op_class()  - groups an opcode by the shape of its execute sequence
//   alu_select()- one-hot alu_op pattern for an opcode
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_HALTED = 4'd8
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01001;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int ALU_W    = 13;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SHR  = 2;
  localparam int ALU_SHRA = 3;
  localparam int ALU_SHL  = 4;
  localparam int ALU_ROR  = 5;
  localparam int ALU_ROL  = 6;
  localparam int ALU_AND  = 7;
  localparam int ALU_OR   = 8;
  localparam int ALU_MUL  = 9;
  localparam int ALU_DIV  = 10;
  localparam int ALU_NEG  = 11;
  localparam int ALU_NOT  = 12;

  typedef enum logic [2:0] {
    CLS_BINARY  = 3'd0,
    CLS_MULDIV  = 3'd1,
    CLS_UNARY   = 3'd2,
    CLS_HALT    = 3'd3,
    CLS_ILLEGAL = 3'd4
  } op_class_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:        return CLS_BINARY;
      OP_MUL, OP_DIV:                         return CLS_MULDIV;
      OP_NEG, OP_NOT:                         return CLS_UNARY;
      OP_HALT:                                return CLS_HALT;
      default:                                return CLS_ILLEGAL;
    endcase
  endfunction

  function automatic logic [ALU_W-1:0] alu_select(input logic [4:0] op);
    logic [ALU_W-1:0] sel;
    sel = '0;
    case (op)
      OP_ADD:  sel[ALU_ADD]  = 1'b1;
      OP_SUB:  sel[ALU_SUB]  = 1'b1;
      OP_AND:  sel[ALU_AND]  = 1'b1;
      OP_OR:   sel[ALU_OR]   = 1'b1;
      OP_SHR:  sel[ALU_SHR]  = 1'b1;
      OP_SHRA: sel[ALU_SHRA] = 1'b1;
      OP_SHL:  sel[ALU_SHL]  = 1'b1;
      OP_ROR:  sel[ALU_ROR]  = 1'b1;
      OP_ROL:  sel[ALU_ROL]  = 1'b1;
      OP_MUL:  sel[ALU_MUL]  = 1'b1;
      OP_DIV:  sel[ALU_DIV]  = 1'b1;
      OP_NEG:  sel[ALU_NEG]  = 1'b1;
      OP_NOT:  sel[ALU_NOT]  = 1'b1;
      default: sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/control_sequencer_reg_select.sv
// reg_select: turns an IR register field into one-hot GPR enables.
//   ra, rb, rc         - 4-bit register fields from IR
//   gra, grb, grc      - choose which field addresses the register file
//   rin_req, rout_req  - request a load (rin) or a bus drive (rout)
//   rin, rout          - 16-bit one-hot enables, bit n = Rn
module reg_select (
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  rc,
  input  logic        gra,
  input  logic        grb,
  input  logic        grc,
  input  logic        rin_req,
  input  logic        rout_req,
  output logic [15:0] rin,
  output logic [15:0] rout
);

  logic [3:0] sel;

  // The sequencer raises at most one field select per cycle; priority only
  // keeps the mux well defined.
  always_comb begin
    sel = 4'd0;
    if (gra)      sel = ra;
    else if (grb) sel = rb;
    else if (grc) sel = rc;
  end

  // With no field selected, no enable may fire, even for R0.
  logic any_sel;
  assign any_sel = gra | grb | grc;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_dec
      assign rin[gi]  = rin_req  && any_sel && (sel == 4'(gi));
      assign rout[gi] = rout_req && any_sel && (sel == 4'(gi));
    end
  endgenerate

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM issuing datapath strobes for fetch/execute.
//   Clock, Clear   - rising-edge clock, asynchronous active-low reset
//   IR             - instruction register (op, Ra, Rb, Rc in [31:15])
//   Stop           - halt request, sampled on an instruction's last state
//   Run            - high except in RESET and HALTED
//   PCout..LOin    - single-bit datapath strobes
//   Rin, Rout      - one-hot GPR load / drive enables
//   alu_op         - one-hot ALU function select
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [12:0] alu_op
);

  state_t state_reg, state_next;

  logic [4:0] op;
  op_class_t  cls;
  logic       gra, grb, grc, rin_req, rout_req, alu_en;
  state_t     done_next;

  assign op  = IR[31:27];
  assign cls = op_class(op);

  // IR[14:0] carries immediates the sequencer never looks at.
  logic unused_ir_bits;
  assign unused_ir_bits = ^IR[14:0];

  // Where to go once the current instruction's last state completes.
  assign done_next = Stop ? S_HALTED : S_T0;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state_reg <= S_RESET;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; Read = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    Zhighout = 1'b0; Zlowout = 1'b0; HIin = 1'b0; LOin = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0;
    rin_req = 1'b0; rout_req = 1'b0; alu_en = 1'b0;
    Run = (state_reg != S_RESET) && (state_reg != S_HALTED);

    case (state_reg)
      S_RESET: state_next = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_next = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        case (cls)
          CLS_BINARY: begin
            grb = 1'b1; rout_req = 1'b1; Yin = 1'b1;
            state_next = S_T4;
          end
          CLS_MULDIV: begin
            gra = 1'b1; rout_req = 1'b1; Yin = 1'b1;
            state_next = S_T4;
          end
          CLS_UNARY: begin
            grb = 1'b1; rout_req = 1'b1; alu_en = 1'b1; Zin = 1'b1;
            state_next = S_T4;
          end
          CLS_HALT: state_next = S_HALTED;
          default:  state_next = done_next;  // illegal: idle cycle, no strobes
        endcase
      end
      S_T4: begin
        case (cls)
          CLS_BINARY: begin
            grc = 1'b1; rout_req = 1'b1; alu_en = 1'b1; Zin = 1'b1;
            state_next = S_T5;
          end
          CLS_MULDIV: begin
            grb = 1'b1; rout_req = 1'b1; alu_en = 1'b1; Zin = 1'b1;
            state_next = S_T5;
          end
          CLS_UNARY: begin
            Zlowout = 1'b1; gra = 1'b1; rin_req = 1'b1;
            state_next = done_next;
          end
          default: state_next = S_T0;
        endcase
      end
      S_T5: begin
        case (cls)
          CLS_BINARY: begin
            Zlowout = 1'b1; gra = 1'b1; rin_req = 1'b1;
            state_next = done_next;
          end
          CLS_MULDIV: begin
            Zlowout = 1'b1; LOin = 1'b1;
            state_next = S_T6;
          end
          default: state_next = S_T0;
        endcase
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
        state_next = done_next;
      end
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_RESET;
    endcase
  end

  assign alu_op = alu_en ? alu_select(op) : '0;

  reg_select u_reg_select (
    .ra       (IR[26:23]),
    .rb       (IR[22:19]),
    .rc       (IR[18:15]),
    .gra      (gra),
    .grb      (grb),
    .grc      (grc),
    .rin_req  (rin_req),
    .rout_req (rout_req),
    .rin      (Rin),
    .rout     (Rout)
  );

endmodule
